// File: rtl/fft_output_serializer_pkg.sv
// rtl/fft_output_serializer_pkg.sv - shared FFT back-end types, size limit and bit-reversal helper
package fft_output_serializer_pkg;

   localparam int MAX_N     = 64;
   localparam int MAX_IDX_W = $clog2(MAX_N);
   localparam int SAMPLE_W  = 16;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] re;
      logic signed [SAMPLE_W-1:0] im;
   } complex_product_t;

   // Reverses the low `width` bits of k; bits above `width` come back as zero.
   function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] k,
                                                   input int width);
      logic [MAX_IDX_W-1:0] r;
      r = '0;
      for (int b = 0; b < MAX_IDX_W; b++) begin
         if (b < width) r[width-1-b] = k[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_output_serializer.sv
// rtl/fft_output_serializer.sv - ping-pong parallel frame to sample stream serializer
// Define OUTPUT_BITREV_EN to emit samples in bit-reversed bin order instead of natural order.
module fft_output_serializer
   import fft_output_serializer_pkg::*;
#(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  complex_product_t [N-1:0]  in_frame,
   output logic                      out_valid,
   input  logic                      out_ready,
   output complex_product_t          out_sample,
   output logic [IDX_W-1:0]          out_index,
   output logic                      out_last
);

   complex_product_t [N-1:0] r_buf0;
   complex_product_t [N-1:0] r_buf1;
   logic [1:0]               r_full;
   logic                     r_wr_sel;
   logic                     r_rd_sel;
   logic [IDX_W-1:0]         r_rd_cnt;

   logic                     w_accept;
   logic                     w_advance;
   logic                     w_end_of_frame;
   logic [IDX_W-1:0]         w_map;

`ifdef OUTPUT_BITREV_EN
   logic [MAX_IDX_W-1:0]     w_rev;
   assign w_rev = bitrev(MAX_IDX_W'(r_rd_cnt), IDX_W);
   assign w_map = w_rev[IDX_W-1:0];
`else
   assign w_map = r_rd_cnt;
`endif

   // Both handshakes depend only on registered state, so in_ready never sees out_ready.
   assign in_ready       = ~r_full[r_wr_sel];
   assign out_valid      = r_full[r_rd_sel];
   assign w_accept       = in_valid & in_ready;
   assign w_advance      = out_valid & out_ready;
   assign w_end_of_frame = (r_rd_cnt == IDX_W'(N-1));

   assign out_index  = w_map;
   assign out_sample = r_rd_sel ? r_buf1[w_map] : r_buf0[w_map];
   assign out_last   = out_valid & w_end_of_frame;

   // Accept targets an empty buffer and advance a full one, so they never collide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf0   <= '0;
         r_buf1   <= '0;
         r_full   <= '0;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_rd_cnt <= '0;
      end else begin
         if (w_accept) begin
            if (r_wr_sel) r_buf1 <= in_frame;
            else          r_buf0 <= in_frame;
            r_full[r_wr_sel] <= 1'b1;
            r_wr_sel         <= ~r_wr_sel;
         end
         if (w_advance) begin
            if (w_end_of_frame) begin
               r_rd_cnt         <= '0;
               r_full[r_rd_sel] <= 1'b0;
               r_rd_sel         <= ~r_rd_sel;
            end else begin
               r_rd_cnt <= r_rd_cnt + 1'b1;
            end
         end
      end
   end

endmodule
